// File: rtl/mips_cpu_pkg.sv
// Shared CPU package: HI/LO op encoding, sequencer states and the ALU ctrl codes
// used by both the HI/LO sequencer and the main decoder.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    OpMult  = 3'd0,
    OpMultu = 3'd1,
    OpDiv   = 3'd2,
    OpDivu  = 3'd3,
    OpMthi  = 3'd4,
    OpMtlo  = 3'd5,
    OpNop   = 3'd6
  } hilo_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StLow,
    StHigh
  } hilo_state_t;

  localparam logic [3:0] ALU_ADD      = 4'b0010;
  localparam logic [3:0] ALU_MULT_LO  = 4'b1000;
  localparam logic [3:0] ALU_MULT_HI  = 4'b1001;
  localparam logic [3:0] ALU_MULTU_LO = 4'b1010;
  localparam logic [3:0] ALU_MULTU_HI = 4'b1011;
  localparam logic [3:0] ALU_DIV_Q    = 4'b1100;
  localparam logic [3:0] ALU_DIV_R    = 4'b1101;
  localparam logic [3:0] ALU_DIVU_Q   = 4'b1110;
  localparam logic [3:0] ALU_DIVU_R   = 4'b1111;

  // ALU code for the pass that produces LO (low product half / quotient)
  function automatic logic [3:0] hilo_low_code(hilo_op_t op);
    case (op)
      OpMultu: return ALU_MULTU_LO;
      OpDiv:   return ALU_DIV_Q;
      OpDivu:  return ALU_DIVU_Q;
      default: return ALU_MULT_LO;
    endcase
  endfunction

  // ALU code for the pass that produces HI (high product half / remainder)
  function automatic logic [3:0] hilo_high_code(hilo_op_t op);
    case (op)
      OpMultu: return ALU_MULTU_HI;
      OpDiv:   return ALU_DIV_R;
      OpDivu:  return ALU_DIVU_R;
      default: return ALU_MULT_HI;
    endcase
  endfunction

endpackage

// File: rtl/mips_cpu_alu.sv
// Combinational CPU ALU: add plus the multiply/divide half-result codes used by
// the HI/LO sequencer. Divide by zero yields quotient 0 and remainder = dividend.
module mips_cpu_alu
  import mips_cpu_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   ctrl,
  output logic [W-1:0] out
);

  logic signed [2*W-1:0] prod_s;
  logic [2*W-1:0]        prod_u;
  logic signed [W-1:0]   q_s, r_s;
  logic [W-1:0]          q_u, r_u;

  // Compute every candidate result, then select by ctrl
  always_comb begin
    prod_s = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    prod_u = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    if (b == '0) begin
      q_s = '0;
      r_s = $signed(a);
      q_u = '0;
      r_u = a;
    end else begin
      q_s = $signed(a) / $signed(b);
      r_s = $signed(a) % $signed(b);
      q_u = a / b;
      r_u = a % b;
    end
    case (ctrl)
      ALU_ADD:      out = a + b;
      ALU_MULT_LO:  out = prod_s[W-1:0];
      ALU_MULT_HI:  out = prod_s[2*W-1:W];
      ALU_MULTU_LO: out = prod_u[W-1:0];
      ALU_MULTU_HI: out = prod_u[2*W-1:W];
      ALU_DIV_Q:    out = q_s;
      ALU_DIV_R:    out = r_s;
      ALU_DIVU_Q:   out = q_u;
      ALU_DIVU_R:   out = r_u;
      default:      out = '0;
    endcase
  end

endmodule

// File: rtl/mips_cpu_hilo_ctrl.sv
// HI/LO sequencer: latches operands, runs a LO pass then a HI pass through the
// shared ALU, optionally preceded by DIV_WAIT settle cycles for divides.
// MTHI/MTLO write HI/LO directly from IDLE without going busy.
// Optional macro MIPS_HILO_DIVZ_EN adds a sticky divide-by-zero flag output `divz`.
module mips_cpu_hilo_ctrl
  import mips_cpu_pkg::*;
#(
  parameter int unsigned W        = 32,
  parameter int unsigned DIV_WAIT = 2,
  parameter int unsigned CW       = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [W-1:0]  rs_val,
  input  logic [W-1:0]  rt_val,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [CW-1:0] alu_ctrl,
  input  logic [W-1:0]  alu_out,
  output logic [W-1:0]  hi,
  output logic [W-1:0]  lo,
  output logic          busy,
  output logic          done
`ifdef MIPS_HILO_DIVZ_EN
  ,
  output logic          divz
`endif
);

  localparam int unsigned CntW = (DIV_WAIT > 1) ? $clog2(DIV_WAIT) : 1;

  hilo_state_t     state_q, state_d;
  hilo_op_t        op_q, op_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    opa_q, opa_d, opb_q, opb_d;
  logic [W-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic [3:0]      ctrl;
  hilo_op_t        op_in;
  logic            is_mul_div, is_div;

  assign op_in      = hilo_op_t'(op);
  assign is_div     = (op_in == OpDiv) || (op_in == OpDivu);
  assign is_mul_div = (op_in == OpMult) || (op_in == OpMultu) || is_div;

  // Next-state: accept ops in IDLE, walk WAIT -> LOW -> HIGH, capture alu_out
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (is_mul_div) begin
            opa_d = rs_val;
            opb_d = rt_val;
            op_d  = op_in;
            if (is_div && (DIV_WAIT > 0)) begin
              state_d = StWait;
              cnt_d   = CntW'(DIV_WAIT - 1);
            end else begin
              state_d = StLow;
            end
          end else if (op_in == OpMthi) begin
            hi_d = rs_val;
          end else if (op_in == OpMtlo) begin
            lo_d = rs_val;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) state_d = StLow;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StLow: begin
        lo_d    = alu_out;
        state_d = StHigh;
      end
      StHigh: begin
        hi_d    = alu_out;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= OpMult;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // ALU ctrl: idle code in IDLE, LO-pass code through WAIT/LOW, HI-pass code in HIGH
  always_comb begin
    ctrl = 4'b0000;
    unique case (state_q)
      StWait, StLow: ctrl = hilo_low_code(op_q);
      StHigh:        ctrl = hilo_high_code(op_q);
      default:       ctrl = 4'b0000;
    endcase
  end

  assign alu_ctrl = CW'(ctrl);
  assign alu_a    = opa_q;
  assign alu_b    = opb_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StHigh);

`ifdef MIPS_HILO_DIVZ_EN
  logic divz_q;

  // Sticky flag: rewritten on every mul/div acceptance, untouched by MTHI/MTLO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divz_q <= 1'b0;
    end else if (start && (state_q == StIdle) && is_mul_div) begin
      divz_q <= is_div && (rt_val == '0);
    end
  end

  assign divz = divz_q;
`endif

endmodule

// File: tb/tb_mips_cpu_hilo_ctrl.sv
// Bench for mips_cpu_hilo_ctrl paired with the real ALU. A timing/arithmetic
// model of each accepted op is compared against the DUT on every falling edge,
// with directed cases pinning literal results.
module tb_mips_cpu_hilo_ctrl;
  import mips_cpu_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned DW = 2;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [W-1:0]  rs_val = '0;
  logic [W-1:0]  rt_val = '0;
  logic [W-1:0]  alu_a, alu_b, alu_out, hi, lo;
  logic [CW-1:0] alu_ctrl;
  logic          busy, done;
`ifdef MIPS_HILO_DIVZ_EN
  logic          divz;
`endif

  always #5 clk = ~clk;

  mips_cpu_hilo_ctrl #(.W(W), .DIV_WAIT(DW), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_ctrl (alu_ctrl),
    .alu_out  (alu_out),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done)
`ifdef MIPS_HILO_DIVZ_EN
    ,
    .divz     (divz)
`endif
  );

  mips_cpu_alu #(.W(W)) alu (
    .a    (alu_a),
    .b    (alu_b),
    .ctrl (alu_ctrl),
    .out  (alu_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {hi, lo}
  function automatic logic [63:0] ref_hilo(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              sa, sb;
    sa = a;
    sb = b;
    case (o)
      3'd0: begin sp = longint'(sa) * longint'(sb); return sp; end
      3'd1: begin up = {32'd0, a} * {32'd0, b}; return up; end
      3'd2: if (b == 0) return {a, 32'd0}; else return {32'(sa % sb), 32'(sa / sb)};
      3'd3: if (b == 0) return {a, 32'd0}; else return {a % b, a / b};
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [3:0] ref_code(input logic [2:0] o, input bit high_pass);
    logic [3:0] c;
    case (o)
      3'd0: c = 4'b1000;
      3'd1: c = 4'b1010;
      3'd2: c = 4'b1100;
      default: c = 4'b1110;
    endcase
    return high_pass ? (c | 4'b0001) : c;
  endfunction

  // Model: an accepted op is "age" edges old; LO lands at age L-1, HI at age L
  logic [W-1:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0, r_hi = '0, r_lo = '0;
  logic [2:0]   m_op = 3'd0;
  bit           m_act = 0, m_divz = 0;
  int           m_age = 0, m_lat = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi = '0; m_lo = '0; m_a = '0; m_b = '0;
      m_act = 0; m_divz = 0; m_age = 0;
    end else if (m_act) begin
      m_age++;
      if (m_age == m_lat - 1) m_lo = r_lo;
      if (m_age == m_lat) begin
        m_hi  = r_hi;
        m_act = 0;
      end
    end else if (start) begin
      if (op <= 3'd3) begin
        m_a  = rs_val;
        m_b  = rt_val;
        m_op = op;
        {r_hi, r_lo} = ref_hilo(op, rs_val, rt_val);
        m_lat  = (op >= 3'd2) ? 2 + DW : 2;
        m_age  = 0;
        m_act  = 1;
        m_divz = (op >= 3'd2) && (rt_val == 0);
      end else if (op == 3'd4) begin
        m_hi = rs_val;
      end else if (op == 3'd5) begin
        m_lo = rs_val;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    bit m_hipass;
    m_hipass = m_act && (m_age == m_lat - 1);
    chk("busy", {31'd0, busy}, {31'd0, m_act});
    chk("done", {31'd0, done}, {31'd0, m_hipass});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_ctrl", {28'd0, alu_ctrl}, m_act ? {28'd0, ref_code(m_op, m_hipass)} : 32'd0);
`ifdef MIPS_HILO_DIVZ_EN
    chk("divz", {31'd0, divz}, {31'd0, m_divz});
`endif
  end

  // Issue one op at a falling edge, then watch until idle (bounded)
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int nb, output int nd, output logic [3:0] c0,
                        output logic [3:0] c1);
    @(negedge clk);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    nb = 0;
    nd = 0;
    c0 = '0;
    c1 = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start  = 1'b0;
      rs_val = $urandom;  // held operands must not follow the inputs
      rt_val = $urandom;
      if (busy) begin
        if (nb == 0) c0 = alu_ctrl;
        c1 = alu_ctrl;
        nb++;
      end
      if (done) nd++;
      if (!busy) break;
    end
    chk("settle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int nb, nd;
    logic [3:0] c0, c1;

    #12;
    chk("reset_hi", hi, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ctrl", {28'd0, alu_ctrl}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: MULT -3 * 5
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, nb, nd, c0, c1);
    chk("t1_lo", lo, 32'hFFFF_FFF1);
    chk("t1_hi", hi, 32'hFFFF_FFFF);
    chk("t1_done_count", nd, 1);
    chk("t1_busy_cycles", nb, 2);

    // 2: MULTU FFFFFFFF * 2
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, nb, nd, c0, c1);
    chk("t2_lo", lo, 32'hFFFF_FFFE);
    chk("t2_hi", hi, 32'h0000_0001);
    chk("t2_ctrl_lo", {28'd0, c0}, 32'b1010);
    chk("t2_ctrl_hi", {28'd0, c1}, 32'b1011);

    // 3: DIV -7 / 2
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, nb, nd, c0, c1);
    chk("t3_busy_cycles", nb, 4);
    chk("t3_lo", lo, 32'hFFFF_FFFD);
    chk("t3_hi", hi, 32'hFFFF_FFFF);

    // 4: DIVU 10 / 0
    run_op(3'd3, 32'h0000_000A, 32'd0, nb, nd, c0, c1);
    chk("t4_lo", lo, 32'd0);
    chk("t4_hi", hi, 32'h0000_000A);
`ifdef MIPS_HILO_DIVZ_EN
    chk("t4_divz_set", {31'd0, divz}, 32'd1);
    run_op(3'd1, 32'd3, 32'd3, nb, nd, c0, c1);
    chk("t4_divz_clr", {31'd0, divz}, 32'd0);
`endif

    // 5a: MTHI in IDLE
    run_op(3'd4, 32'h1234_5678, 32'd0, nb, nd, c0, c1);
    chk("t5_hi", hi, 32'h1234_5678);
    chk("t5_busy", nb, 0);
    chk("t5_done", nd, 0);

    // 5b: MTLO while a MULT runs is ignored
    @(negedge clk);
    start = 1'b1; op = 3'd0; rs_val = 32'd7; rt_val = 32'd6;
    @(negedge clk);
    op = 3'd5; rs_val = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    chk("t5_lo_product", lo, 32'h0000_002A);
    chk("t5_hi_product", hi, 32'd0);

    // 6: reset during the WAIT phase of a DIV
    run_op(3'd4, 32'h5555_AAAA, 32'd0, nb, nd, c0, c1);
    @(negedge clk);
    start = 1'b1; op = 3'd2; rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0;
    chk("t6_busy_before", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_hi_rst", hi, 32'd0);
    chk("t6_lo_rst", lo, 32'd0);
    chk("t6_busy_rst", {31'd0, busy}, 32'd0);
    chk("t6_done_rst", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd0, 32'd3, 32'd4, nb, nd, c0, c1);
    chk("t6_lo_after", lo, 32'h0000_000C);
    chk("t6_done_after", nd, 1);

    // Random traffic, including starts while busy and no-op codes
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      start  = ($urandom_range(0, 2) == 0);
      op     = 3'($urandom_range(0, 7));
      rs_val = $urandom;
      rt_val = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (rs_val == 32'h8000_0000 && rt_val == 32'hFFFF_FFFF) rt_val = 32'd1;
    end
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    chk("final_idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_cpu_hilo_ctrl.md
Name: mips_cpu_hilo_ctrl

Overview:
Multi-cycle sequencer that owns the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It latches the operands and drives the ALU's ctrl and a/b inputs for one low-half pass and one high-half pass, capturing `out` into LO and then HI. A configurable wait phase before divides gives the ALU divider multicycle timing margin. `busy` stalls the CPU pipeline, which must not issue MFHI or MFLO while it is high.

Parameters:
W, 32, datapath width of operands, ALU ports and HI/LO
DIV_WAIT, 2, idle cycles inserted before the LO capture for DIV/DIVU; 0 is legal
CW, 4, ALU ctrl width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request strobe, one cycle; sampled only in IDLE
op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 = no-op
rs_val  in  W  first operand (dividend/multiplicand, MTHI/MTLO source)
rt_val  in  W  second operand
alu_a  out  W  to ALU a
alu_b  out  W  to ALU b
alu_ctrl  out  CW  to ALU ctrl
alu_out  in  W  from ALU out
hi  out  W  architectural HI
lo  out  W  architectural LO
busy  out  1  high while state != IDLE
done  out  1  one-cycle pulse in the cycle HI is written

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; hi=0, lo=0, opa=0, opb=0, cnt=0.
  - busy=0, done=0, alu_ctrl=4'b0000, alu_a=0, alu_b=0.
- States: IDLE, WAIT, LOW, HIGH.
- IDLE:
  - alu_ctrl=0000; alu_a/alu_b driven from opa/opb.
  - start with op 0-3: latch opa=rs_val, opb=rt_val, op_q=op.
    - Divide with DIV_WAIT>0 -> WAIT, cnt=DIV_WAIT-1.
    - Otherwise -> LOW.
  - start with op 4: hi<=rs_val in the same edge; stay IDLE; no busy, no done.
  - start with op 5: lo<=rs_val in the same edge; stay IDLE; no busy, no done.
  - op 6/7: ignored.
- WAIT:
  - alu_ctrl=low code of op_q; a/b=opa/opb.
  - cnt decrements each cycle; cnt==0 -> LOW.
- LOW:
  - Drive low code: MULT 1000, MULTU 1010, DIV 1100, DIVU 1110.
  - lo<=alu_out at the clock edge; -> HIGH.
- HIGH:
  - Drive high code: MULT 1001, MULTU 1011, DIV 1101, DIVU 1111.
  - hi<=alu_out; done=1 (combinational on state==HIGH); -> IDLE.
- Latency from the start edge to hi/lo valid:
  - Multiply: 2 cycles.
  - Divide: 2+DIV_WAIT cycles.
  - The next start is accepted in the cycle after done.
- start while busy: ignored, including MTHI/MTLO. The CPU guarantees this never happens; the bench asserts it.
- Divide by zero: no special handling; the ALU result is captured (quotient 0, remainder = dividend).
- rs_val/rt_val changes after acceptance have no effect, because opa/opb are held.
- Reset mid-operation aborts immediately: hi/lo clear to 0, no done pulse.
- HI and LO are updated in separate cycles. Intermediate lo-new/hi-old is visible only while busy=1.

Optional Feature:
MIPS_HILO_DIVZ_EN
- Defined:
  - Adds output `divz` (1 bit) and a sticky flag register.
  - The flag sets when a DIV/DIVU is accepted with rt_val==0.
  - It clears on reset or on the acceptance of any subsequent op 0-3; MTHI/MTLO leave it unchanged.
  - `divz` is valid from the cycle after acceptance.
- Undefined: no port and no logic; divide-by-zero behaves as specified above.

Decomposition:
- Shared package mips_cpu_pkg:
  - enum hilo_op_t (6 ops plus NOP).
  - enum hilo_state_t.
  - ALU ctrl localparams: ALU_MULT_LO/HI, ALU_MULTU_LO/HI, ALU_DIV_Q/R, ALU_DIVU_Q/R, ALU_ADD.
  - The same ctrl constants are used by the main decoder.
- Sub-modules: none needed. The wait counter is inline.
- Bench: the ALU is instantiated alongside as a real DUT partner, not a model.

Test Plan:
1. MULT rs=FFFFFFFD (-3), rt=5 -> after 2 cycles lo=FFFFFFF1, hi=FFFFFFFF; done pulses once; busy high exactly 2 cycles.
2. MULTU rs=FFFFFFFF, rt=2 -> lo=FFFFFFFE, hi=00000001; alu_ctrl sequence 1010 then 1011.
3. DIV rs=FFFFFFF9 (-7), rt=2, DIV_WAIT=2 -> busy 4 cycles; lo=FFFFFFFD, hi=FFFFFFFF.
4. DIVU rs=0000000A, rt=0 -> lo=0, hi=0000000A. With MIPS_HILO_DIVZ_EN, divz=1; a following MULTU clears it.
5. MTHI 12345678 in IDLE -> hi=12345678 next edge, busy stays 0. MTLO issued during a running MULT -> ignored; lo ends at the product.
6. rst_n asserted in the WAIT cycle of a DIV -> hi=lo=0 and busy=0 immediately (async); no done pulse; a new MULT after release completes normally.
